// File: rtl/divider_pow2_shared_scheduler.sv
// Round-robin scheduler that lets REQ_COUNT clients share one signed power-of-two
// divider. Results come back registered and tagged with the issuing requester.
module divider_pow2_shared_scheduler #(
   parameter int unsigned WORD_WIDTH      = 16,
   parameter int unsigned REQ_COUNT       = 4,
   parameter int unsigned REQ_INDEX_WIDTH = 2
) (
   input  logic                            clock,
   input  logic                            clear_n,
   input  logic [REQ_COUNT-1:0]            in_valid,
   output logic [REQ_COUNT-1:0]            in_ready,
   input  logic [REQ_COUNT*WORD_WIDTH-1:0] in_numerator,
   input  logic [REQ_COUNT*WORD_WIDTH-1:0] in_exponent,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [WORD_WIDTH-1:0]           out_quotient,
   output logic [WORD_WIDTH-1:0]           out_remainder,
   output logic [REQ_INDEX_WIDTH-1:0]      out_requester,
   output logic                            out_clamped,
   output logic                            busy
);

   localparam int unsigned W     = WORD_WIDTH;
   localparam int unsigned SEL_W = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      RESPOND = 2'd2
   } state_t;

   state_t                     state_q, state_d;
   logic [REQ_INDEX_WIDTH-1:0] rr_q, rr_d;
   logic [W-1:0]               op_num_q, op_num_d;
   logic [W-1:0]               op_exp_q, op_exp_d;
   logic [REQ_INDEX_WIDTH-1:0] op_tag_q, op_tag_d;
   logic [W-1:0]               quot_d, rem_d;
   logic [REQ_INDEX_WIDTH-1:0] req_d;
   logic                       clamped_d, valid_d, busy_d;

   logic [W-1:0] num_arr [REQ_COUNT];
   logic [W-1:0] exp_arr [REQ_COUNT];

   for (genvar i = 0; i < int'(REQ_COUNT); i++) begin : g_unpack
      assign num_arr[i] = in_numerator[i*W +: W];
      assign exp_arr[i] = in_exponent[i*W +: W];
   end

   // Round-robin search starting at rr_q.
   logic             grant_valid;
   logic [SEL_W-1:0] grant_sel;
   int               idx;

   always_comb begin
      grant_valid = 1'b0;
      grant_sel   = '0;
      idx         = 0;
      for (int k = 0; k < int'(REQ_COUNT); k++) begin
         idx = int'(rr_q) + k;
         if (idx >= int'(REQ_COUNT)) idx = idx - int'(REQ_COUNT);
         if (!grant_valid && in_valid[SEL_W'(idx)]) begin
            grant_valid = 1'b1;
            grant_sel   = SEL_W'(idx);
         end
      end
   end

   // Shared divider: arithmetic shift rounds toward -inf, so bump negative inexact results.
   logic [W-1:0] low_bits, shifted, div_q, div_r, res_q, res_r;
   logic         round_up, clamp;

   always_comb begin
      low_bits = op_num_q & ~({W{1'b1}} << op_exp_q);
      shifted  = W'($signed(op_num_q) >>> op_exp_q);
      round_up = op_num_q[W-1] && (low_bits != '0);
      div_q    = shifted + W'(round_up);
      div_r    = op_num_q - (div_q << op_exp_q);
      clamp    = (op_exp_q >= W'(WORD_WIDTH));
      res_q    = clamp ? '0 : div_q;
      res_r    = clamp ? op_num_q : div_r;
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      op_num_d  = op_num_q;
      op_exp_d  = op_exp_q;
      op_tag_d  = op_tag_q;
      quot_d    = out_quotient;
      rem_d     = out_remainder;
      req_d     = out_requester;
      clamped_d = out_clamped;
      valid_d   = out_valid;
      in_ready  = '0;
      case (state_q)
         IDLE: begin
            if (grant_valid && clear_n) begin
               in_ready[grant_sel] = 1'b1;
               op_num_d = num_arr[grant_sel];
               op_exp_d = exp_arr[grant_sel];
               op_tag_d = REQ_INDEX_WIDTH'(grant_sel);
               rr_d     = (grant_sel == SEL_W'(REQ_COUNT - 1)) ? '0
                          : REQ_INDEX_WIDTH'(grant_sel) + REQ_INDEX_WIDTH'(1);
               state_d  = COMPUTE;
            end
         end
         COMPUTE: begin
            quot_d    = res_q;
            rem_d     = res_r;
            req_d     = op_tag_q;
            clamped_d = clamp;
            valid_d   = 1'b1;
            state_d   = RESPOND;
         end
         RESPOND: begin
            if (out_ready) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state_q       <= IDLE;
         rr_q          <= '0;
         op_num_q      <= '0;
         op_exp_q      <= '0;
         op_tag_q      <= '0;
         out_quotient  <= '0;
         out_remainder <= '0;
         out_requester <= '0;
         out_clamped   <= 1'b0;
         out_valid     <= 1'b0;
         busy          <= 1'b0;
      end else begin
         state_q       <= state_d;
         rr_q          <= rr_d;
         op_num_q      <= op_num_d;
         op_exp_q      <= op_exp_d;
         op_tag_q      <= op_tag_d;
         out_quotient  <= quot_d;
         out_remainder <= rem_d;
         out_requester <= req_d;
         out_clamped   <= clamped_d;
         out_valid     <= valid_d;
         busy          <= busy_d;
      end
   end

endmodule

// File: tb/tb_divider_pow2_shared_scheduler.sv
// Bench for divider_pow2_shared_scheduler: transaction-level model checked every
// cycle, plus directed transactions with literal expected results.
module tb_divider_pow2_shared_scheduler;

   localparam int W  = 8;
   localparam int N  = 4;
   localparam int IW = 2;

   logic           clock;
   logic           clear_n;
   logic [N-1:0]   in_valid;
   logic [N-1:0]   in_ready;
   logic [N*W-1:0] in_numerator;
   logic [N*W-1:0] in_exponent;
   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   out_quotient;
   logic [W-1:0]   out_remainder;
   logic [IW-1:0]  out_requester;
   logic           out_clamped;
   logic           busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   divider_pow2_shared_scheduler #(
      .WORD_WIDTH(W), .REQ_COUNT(N), .REQ_INDEX_WIDTH(IW)
   ) dut (
      .clock(clock), .clear_n(clear_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_numerator(in_numerator), .in_exponent(in_exponent),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_quotient(out_quotient), .out_remainder(out_remainder),
      .out_requester(out_requester), .out_clamped(out_clamped),
      .busy(busy)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: phase 0 waiting for grant, 1 dividing, 2 result offered.
   int          m_phase = 0;
   int          m_rr    = 0;
   int          m_req   = 0;
   int          m_g     = 0;
   logic [W-1:0] m_q    = '0;
   logic [W-1:0] m_r    = '0;
   logic         m_cl   = 1'b0;

   function automatic int pick(input logic [N-1:0] v, input int rr);
      for (int k = 0; k < N; k++) begin
         if (v[(rr + k) % N]) return (rr + k) % N;
      end
      return -1;
   endfunction

   task automatic model_accept(input int g);
      logic [W-1:0] num, e;
      int n, d;
      num = W'(in_numerator >> (g * W));
      e   = W'(in_exponent >> (g * W));
      n   = int'($signed(num));
      m_req = g;
      if (e >= W) begin
         m_q = '0; m_r = num; m_cl = 1'b1;
      end else begin
         d = 1 << e;
         m_q = W'(n / d); m_r = W'(n % d); m_cl = 1'b0;
      end
   endtask

   always @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         m_phase = 0;
         m_rr    = 0;
      end else begin
         cyc++;
         case (m_phase)
            0: begin
               m_g = pick(in_valid, m_rr);
               if (m_g >= 0) begin
                  model_accept(m_g);
                  m_rr    = (m_g + 1) % N;
                  m_phase = 1;
               end
            end
            1: m_phase = 2;
            default: if (out_ready) m_phase = 0;
         endcase
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clock) begin
      logic [N-1:0] er;
      int g;
      if (!clear_n) begin
         check("rst_in_ready", 32'(in_ready), 0);
         check("rst_out_valid", 32'(out_valid), 0);
         check("rst_busy", 32'(busy), 0);
         check("rst_quotient", 32'(out_quotient), 0);
         check("rst_clamped", 32'(out_clamped), 0);
      end else begin
         er = '0;
         if (m_phase == 0) begin
            g = pick(in_valid, m_rr);
            if (g >= 0) er = N'(1) << g;
         end
         check("in_ready", 32'(in_ready), 32'(er));
         check("out_valid", 32'(out_valid), 32'(m_phase == 2));
         check("busy", 32'(busy), 32'(m_phase != 0));
         if (m_phase == 2) begin
            check("quotient", 32'(out_quotient), 32'(m_q));
            check("remainder", 32'(out_remainder), 32'(m_r));
            check("requester", 32'(out_requester), 32'(m_req));
            check("clamped", 32'(out_clamped), 32'(m_cl));
         end
      end
   end

   task automatic set_req(input int r, input logic [W-1:0] num, input logic [W-1:0] e);
      in_numerator = (in_numerator & ~(32'hFF << (r * W))) | (32'(num) << (r * W));
      in_exponent  = (in_exponent  & ~(32'hFF << (r * W))) | (32'(e)   << (r * W));
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 20 && busy; i++) begin
         @(posedge clock); #1;
      end
      check("wait_idle", 32'(busy), 0);
   endtask

   task automatic do_reset();
      clear_n = 1'b0;
      @(posedge clock); #1;
      clear_n = 1'b1;
   endtask

   // One isolated transaction from an idle block with out_ready held high.
   task automatic txn(input int r, input logic [W-1:0] num, input logic [W-1:0] e,
                      input logic [W-1:0] eq, input logic [W-1:0] er, input logic ecl);
      set_req(r, num, e);
      in_valid = N'(1) << r;
      @(posedge clock); #1;
      check("txn_accept_busy", 32'(busy), 1);
      in_valid = '0;
      @(posedge clock); #1;
      check("txn_latency_valid", 32'(out_valid), 1);
      check("txn_quotient", 32'(out_quotient), 32'(eq));
      check("txn_remainder", 32'(out_remainder), 32'(er));
      check("txn_requester", 32'(out_requester), 32'(r));
      check("txn_clamped", 32'(out_clamped), 32'(ecl));
      @(posedge clock); #1;
      check("txn_back_idle", 32'(busy), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int prev;
      int t;
      clear_n      = 1'b0;
      in_valid     = '0;
      in_numerator = '0;
      in_exponent  = '0;
      out_ready    = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      check("reset_quotient", 32'(out_quotient), 0);
      check("reset_remainder", 32'(out_remainder), 0);
      check("reset_requester", 32'(out_requester), 0);
      check("reset_clamped", 32'(out_clamped), 0);
      check("reset_valid", 32'(out_valid), 0);
      check("reset_busy", 32'(busy), 0);
      clear_n = 1'b1;
      @(posedge clock); #1;

      // Arithmetic and clamp vectors
      txn(1, 8'hF9, 8'd1, 8'hFD, 8'hFF, 1'b0);
      txn(0, 8'h07, 8'd1, 8'h03, 8'h01, 1'b0);
      txn(2, 8'hF8, 8'd2, 8'hFE, 8'h00, 1'b0);
      txn(3, 8'h80, 8'd7, 8'hFF, 8'h00, 1'b0);
      txn(1, 8'h55, 8'd0, 8'h55, 8'h00, 1'b0);
      txn(2, 8'hFB, 8'd9, 8'h00, 8'hFB, 1'b1);
      txn(0, 8'hFB, 8'd8, 8'h00, 8'hFB, 1'b1);

      // Round-robin order from reset, one grant every 3 cycles
      do_reset();
      for (int n = 0; n < N; n++) set_req(n, W'(n + 1), 8'd0);
      in_valid = '1;
      prev = 0;
      for (int n = 0; n < N; n++) begin
         @(negedge clock);
         for (int i = 0; i < 10 && in_ready == '0; i++) @(negedge clock);
         check("rr_grant", 32'(in_ready), 32'(N'(1) << n));
         t = cyc;
         if (n > 0) check("rr_spacing", 32'(t - prev), 3);
         prev = t;
         @(posedge clock); #1;
         in_valid = in_valid & ~(N'(1) << n);
      end
      wait_idle();
      in_valid = '1;
      @(negedge clock);
      check("rr_wrap", 32'(in_ready), 32'(4'b0001));
      @(posedge clock); #1;
      in_valid = '0;
      wait_idle();
      txn(1, 8'h07, 8'd1, 8'h03, 8'h01, 1'b0);
      in_valid = 4'b1001;
      @(negedge clock);
      check("rr_skip_to_3", 32'(in_ready), 32'(4'b1000));
      @(posedge clock); #1;
      in_valid = '0;
      wait_idle();

      // Backpressure while the result is offered
      out_ready = 1'b0;
      set_req(2, 8'h07, 8'd1);
      in_valid = 4'b0100;
      @(posedge clock); #1;
      in_valid = '0;
      @(posedge clock); #1;
      in_valid = '1;
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", 32'(out_valid), 1);
         check("bp_quotient", 32'(out_quotient), 32'h03);
         check("bp_remainder", 32'(out_remainder), 32'h01);
         check("bp_requester", 32'(out_requester), 2);
         check("bp_in_ready", 32'(in_ready), 0);
         check("bp_busy", 32'(busy), 1);
         @(posedge clock); #1;
      end
      in_valid  = '0;
      out_ready = 1'b1;
      @(posedge clock); #1;
      check("bp_release_valid", 32'(out_valid), 0);
      check("bp_release_busy", 32'(busy), 0);

      // Reset during COMPUTE
      set_req(1, 8'hF9, 8'd1);
      in_valid = 4'b0010;
      @(posedge clock); #1;
      in_valid = '0;
      #2 clear_n = 1'b0;
      #1;
      check("rc_valid", 32'(out_valid), 0);
      check("rc_busy", 32'(busy), 0);
      @(posedge clock); #1;
      clear_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clock); #1;
         check("rc_no_stale", 32'(out_valid), 0);
      end

      // Reset during RESPOND
      out_ready = 1'b0;
      set_req(2, 8'h07, 8'd1);
      in_valid = 4'b0100;
      @(posedge clock); #1;
      in_valid = '0;
      @(posedge clock); #1;
      check("rr_resp_valid", 32'(out_valid), 1);
      #2 clear_n = 1'b0;
      #1;
      check("rr_resp_dropped", 32'(out_valid), 0);
      check("rr_resp_quotient", 32'(out_quotient), 0);
      @(posedge clock); #1;
      clear_n   = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clock); #1;
         check("rr_resp_no_stale", 32'(out_valid), 0);
      end
      in_valid = '1;
      @(negedge clock);
      check("post_reset_grant0", 32'(in_ready), 32'(4'b0001));
      @(posedge clock); #1;
      in_valid = '0;
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/divider_pow2_shared_scheduler.md
Name: divider_pow2_shared_scheduler

Overview:
Shares one combinational signed power-of-two truncating divider among REQ_COUNT requesters. Arbitration is round-robin. Each side has a valid/ready handshake. The divider's operands and results are registered. Each result is returned tagged with the index of the requester that issued it. The block sits between several datapath clients and a single divider instance, so each client does not need its own divider.

Parameters:
WORD_WIDTH, 16, width of numerator, exponent, quotient and remainder
REQ_COUNT, 4, number of requesters (≥2)
REQ_INDEX_WIDTH, 2, width of requester tag, ≥ clog2(REQ_COUNT)

Ports:
clock  input  1  clock, all state on rising edge
clear_n  input  1  asynchronous active-low reset
in_valid  input  REQ_COUNT  per-requester request valid
in_ready  output  REQ_COUNT  per-requester accept; at most one bit high
in_numerator  input  REQ_COUNT*WORD_WIDTH  packed signed numerators, requester i at [i*WORD_WIDTH +: WORD_WIDTH]
in_exponent  input  REQ_COUNT*WORD_WIDTH  packed unsigned exponents, same packing
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_quotient  output  WORD_WIDTH  signed truncated quotient
out_remainder  output  WORD_WIDTH  signed remainder, sign of numerator or zero
out_requester  output  REQ_INDEX_WIDTH  index of requester that issued this result
out_clamped  output  1  exponent was ≥ WORD_WIDTH and the result was substituted
busy  output  1  high whenever state is not IDLE

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low. clock and clear_n are the only clock/reset ports.
- Reset values:
  - state = IDLE
  - rr_pointer = 0
  - in_ready = 0
  - out_valid = 0, out_clamped = 0, busy = 0
  - out_quotient, out_remainder, out_requester = 0
- State machine: IDLE → COMPUTE → RESPOND → IDLE.
- IDLE, arbitration:
  - grant = first i with in_valid[i]=1, searching rr_pointer, rr_pointer+1, … modulo REQ_COUNT.
  - in_ready[grant] = 1; all other in_ready bits = 0. in_ready is combinational from state, in_valid and rr_pointer.
  - With no valid requester, in_ready = 0 and the block stays in IDLE.
- IDLE, handshake: when in_valid[g] && in_ready[g], on that edge:
  - latch numerator, exponent and tag g into operand registers;
  - rr_pointer ← (g+1) mod REQ_COUNT;
  - state → COMPUTE.
- COMPUTE:
  - the divider is fed from the operand registers;
  - on the edge, its quotient and remainder are registered into out_quotient and out_remainder, out_requester ← tag, out_valid ← 1, state → RESPOND.
- Clamp: if the latched exponent ≥ WORD_WIDTH (unsigned compare), out_quotient ← 0, out_remainder ← latched numerator, out_clamped ← 1. Otherwise out_clamped ← 0.
- RESPOND:
  - outputs are held stable while out_ready = 0;
  - on out_valid && out_ready: out_valid ← 0, state → IDLE.
  - No request is accepted in COMPUTE or RESPOND; in_ready = 0 in both.
- Timing:
  - Latency from accept edge to out_valid high is 2 edges.
  - Peak throughput is one transaction per 3 cycles when out_ready is held at 1.
- Arithmetic, for 0 ≤ exponent < WORD_WIDTH:
  - quotient = numerator / 2^exponent, truncated toward zero;
  - remainder = numerator − quotient·2^exponent;
  - exponent 0 gives quotient = numerator and remainder = 0.
- Requester obligations: hold in_valid and operands stable until accepted. Dropping in_valid before acceptance withdraws the request and has no side effect.
- Simultaneous requests: only the granted requester advances. The others keep waiting, and the round-robin order guarantees no starvation.
- Wrap-around: rr_pointer goes from REQ_COUNT−1 to 0.
- Reset mid-operation: clear_n low in any state returns immediately to reset values. Any latched operands or pending result are discarded and never presented.

Test Plan:
(WORD_WIDTH=8, REQ_COUNT=4)
- Signed division: requester 1 sends num=−7 (0xF9), exp=1 → out_quotient=0xFD (−3), out_remainder=0xFF (−1), out_requester=1, out_clamped=0. out_valid rises 2 edges after accept.
- Positive and exact cases:
  - num=7, exp=1 → 3, 1;
  - num=−8, exp=2 → 0xFE, 0;
  - num=−128, exp=7 → 0xFF, 0;
  - num=0x55, exp=0 → 0x55, 0.
- Clamp: num=−5, exp=9 → quotient 0, remainder 0xFB, out_clamped=1. Repeat with exp=8 → same result.
- Round-robin: all four in_valid high from reset, out_ready=1 → grants in order 0,1,2,3, one every 3 cycles. Re-asserting all four then gives grant 0 again. With rr_pointer=2 and only requesters 0 and 3 valid → grant 3 first.
- Backpressure: hold out_ready=0 for 5 cycles in RESPOND → outputs stable, in_ready=0 throughout, busy=1. Raising out_ready → IDLE on the next edge.
- Reset: pulse clear_n low during COMPUTE, then again during RESPOND → out_valid drops immediately and no stale result appears after release. The next grant starts from requester 0.
